sd_cmd_phys: RTL and testbench

CMD-line physical layer of the SD host. It sits directly downstream of the CMD internal controller. It serializes a 48-bit command frame with CRC7 onto the card CMD line and waits for the card's response, which it captures as a 48-bit or 136-bit frame. It returns the response, timeout and CRC status to the controller through a strobe/ack handshake.

---
 rtl/sd_cmd_phys_if.sv | 31 +++
 rtl/sd_cmd_phys.sv | 230 +++++++++++++++++++++++
 tb/tb_sd_cmd_phys.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_phys_if.sv
// Signal bundle between the SD CMD internal controller / card line and the
// CMD-line physical layer. The phy uses the slave view.
interface sd_cmd_phys_if;
    logic         send_strobe;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_argument;
    logic         response_expected;
    logic         response_long;
    logic         timeout_enable;
    logic         ack_out;
    logic         cmd_pin_in;
    logic         cmd_out;
    logic         cmd_oe;
    logic [127:0] response;
    logic         strobe_out;
    logic         time_out;
    logic         crc_error;
    logic         busy;

    modport master (
        output send_strobe, cmd_index, cmd_argument, response_expected,
               response_long, timeout_enable, ack_out, cmd_pin_in,
        input  cmd_out, cmd_oe, response, strobe_out, time_out, crc_error, busy
    );

    modport slave (
        input  send_strobe, cmd_index, cmd_argument, response_expected,
               response_long, timeout_enable, ack_out, cmd_pin_in,
        output cmd_out, cmd_oe, response, strobe_out, time_out, crc_error, busy
    );
endinterface

// File: rtl/sd_cmd_phys.sv
// SD CMD-line physical layer: serializes a 48-bit command with CRC7 and
// captures the card's 48/136-bit response, reporting via strobe/ack.
module sd_cmd_phys #(
    parameter int RESP_TIMEOUT = 64
) (
    input  logic          clock,
    input  logic          reset,
    sd_cmd_phys_if.slave  bus
);

    localparam int WAIT_W = $clog2(RESP_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_RECEIVE   = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Serial CRC7 (x^7 + x^3 + 1), one bit per call.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    state_t              state_r, state_s;
    logic                cmd_out_r, cmd_out_s;
    logic                cmd_oe_r, cmd_oe_s;
    logic                busy_r, busy_s;
    logic                strobe_r, strobe_s;
    logic                time_out_r, time_out_s;
    logic                crc_error_r, crc_error_s;
    logic [127:0]        response_r, response_s;
    logic [39:0]         tx_r, tx_s;
    logic [127:0]        rx_r, rx_s;
    logic [6:0]          crc_r, crc_s;
    logic [7:0]          bit_cnt_r, bit_cnt_s;
    logic [WAIT_W-1:0]   wait_cnt_r, wait_cnt_s;
    logic                resp_exp_r, resp_exp_s;
    logic                resp_long_r, resp_long_s;
    logic                to_en_r, to_en_s;
    logic [39:0]         frame_s;
    logic [127:0]        rx_shift_s;
    logic [7:0]          last_bit_s;

    // Next-state and next-register computation for the whole datapath.
    always_comb begin
        state_s     = state_r;
        cmd_out_s   = cmd_out_r;
        cmd_oe_s    = cmd_oe_r;
        strobe_s    = strobe_r;
        time_out_s  = time_out_r;
        crc_error_s = crc_error_r;
        response_s  = response_r;
        tx_s        = tx_r;
        rx_s        = rx_r;
        crc_s       = crc_r;
        bit_cnt_s   = bit_cnt_r;
        wait_cnt_s  = wait_cnt_r;
        resp_exp_s  = resp_exp_r;
        resp_long_s = resp_long_r;
        to_en_s     = to_en_r;
        frame_s     = {1'b0, 1'b1, bus.cmd_index, bus.cmd_argument};
        rx_shift_s  = {rx_r[126:0], bus.cmd_pin_in};
        last_bit_s  = resp_long_r ? 8'd135 : 8'd47;

        case (state_r)
            ST_IDLE: begin
                cmd_oe_s  = 1'b0;
                cmd_out_s = 1'b1;
                if (bus.send_strobe) begin
                    // Start bit goes out in the very next cycle, so it is
                    // registered here and the rest of the header is queued.
                    state_s     = ST_SEND;
                    cmd_oe_s    = 1'b1;
                    cmd_out_s   = frame_s[39];
                    tx_s        = {frame_s[38:0], 1'b0};
                    crc_s       = crc7_step(7'd0, frame_s[39]);
                    bit_cnt_s   = 8'd1;
                    wait_cnt_s  = '0;
                    resp_exp_s  = bus.response_expected;
                    resp_long_s = bus.response_long;
                    to_en_s     = bus.timeout_enable;
                    time_out_s  = 1'b0;
                    crc_error_s = 1'b0;
                    response_s  = '0;
                    rx_s        = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SEND: begin
                if (bit_cnt_r < 8'd40) begin
                    cmd_out_s = tx_r[39];
                    tx_s      = {tx_r[38:0], 1'b0};
                    crc_s     = crc7_step(crc_r, tx_r[39]);
                    bit_cnt_s = bit_cnt_r + 8'd1;
                end else if (bit_cnt_r < 8'd47) begin
                    cmd_out_s = crc_r[6];
                    crc_s     = {crc_r[5:0], 1'b0};
                    bit_cnt_s = bit_cnt_r + 8'd1;
                end else if (bit_cnt_r == 8'd47) begin
                    cmd_out_s = 1'b1;
                    bit_cnt_s = bit_cnt_r + 8'd1;
                end else begin
                    cmd_oe_s  = 1'b0;
                    cmd_out_s = 1'b1;
                    if (resp_exp_r) begin
                        state_s    = ST_WAIT_RESP;
                        wait_cnt_s = '0;
                    end else begin
                        state_s  = ST_DONE;
                        strobe_s = 1'b1;
                    end
                end
            end

            ST_WAIT_RESP: begin
                cmd_oe_s  = 1'b0;
                cmd_out_s = 1'b1;
                if (!bus.cmd_pin_in) begin
                    // The start bit is received bit 0 and feeds the CRC.
                    state_s   = ST_RECEIVE;
                    rx_s      = rx_shift_s;
                    crc_s     = crc7_step(7'd0, 1'b0);
                    bit_cnt_s = 8'd1;
                end else if (to_en_r && (wait_cnt_r == WAIT_W'(RESP_TIMEOUT - 1))) begin
                    state_s    = ST_DONE;
                    time_out_s = 1'b1;
                    strobe_s   = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + WAIT_W'(1);
                end
            end

            ST_RECEIVE: begin
                rx_s = rx_shift_s;
                if (bit_cnt_r < 8'd40) begin
                    crc_s = crc7_step(crc_r, bus.cmd_pin_in);
                end else begin
                    crc_s = crc_r;
                end
                if (bit_cnt_r == last_bit_s) begin
                    state_s  = ST_DONE;
                    strobe_s = 1'b1;
                    if (resp_long_r) begin
                        response_s  = rx_shift_s;
                        crc_error_s = 1'b0;
                    end else begin
                        response_s  = {90'd0, rx_shift_s[45:8]};
                        crc_error_s = (rx_shift_s[7:1] != crc_r) | ~rx_shift_s[0];
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r + 8'd1;
                end
            end

            ST_DONE: begin
                cmd_oe_s  = 1'b0;
                cmd_out_s = 1'b1;
                if (bus.ack_out) begin
                    state_s  = ST_IDLE;
                    strobe_s = 1'b0;
                end else begin
                    strobe_s = 1'b1;
                end
            end

            default: begin
                state_s   = ST_IDLE;
                cmd_oe_s  = 1'b0;
                cmd_out_s = 1'b1;
                strobe_s  = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cmd_out_r   <= 1'b1;
            cmd_oe_r    <= 1'b0;
            busy_r      <= 1'b0;
            strobe_r    <= 1'b0;
            time_out_r  <= 1'b0;
            crc_error_r <= 1'b0;
            response_r  <= '0;
            tx_r        <= '0;
            rx_r        <= '0;
            crc_r       <= 7'd0;
            bit_cnt_r   <= 8'd0;
            wait_cnt_r  <= '0;
            resp_exp_r  <= 1'b0;
            resp_long_r <= 1'b0;
            to_en_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            cmd_out_r   <= cmd_out_s;
            cmd_oe_r    <= cmd_oe_s;
            busy_r      <= busy_s;
            strobe_r    <= strobe_s;
            time_out_r  <= time_out_s;
            crc_error_r <= crc_error_s;
            response_r  <= response_s;
            tx_r        <= tx_s;
            rx_r        <= rx_s;
            crc_r       <= crc_s;
            bit_cnt_r   <= bit_cnt_s;
            wait_cnt_r  <= wait_cnt_s;
            resp_exp_r  <= resp_exp_s;
            resp_long_r <= resp_long_s;
            to_en_r     <= to_en_s;
        end
    end

    assign bus.cmd_out    = cmd_out_r;
    assign bus.cmd_oe     = cmd_oe_r;
    assign bus.busy       = busy_r;
    assign bus.strobe_out = strobe_r;
    assign bus.time_out   = time_out_r;
    assign bus.crc_error  = crc_error_r;
    assign bus.response   = response_r;

endmodule

// File: tb/tb_sd_cmd_phys.sv
// Bench for sd_cmd_phys: table of transactions with a scoreboard checked on
// each strobe_out rise, plus hand-written reset and no-timeout sequences.
module tb_sd_cmd_phys;
    localparam int RT = 20;

    logic clock = 1'b0;
    logic reset;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    sd_cmd_phys_if bus();

    sd_cmd_phys #(.RESP_TIMEOUT(RT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Cycle number: value seen during a cycle; posedge ends that cycle.
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [127:0] resp;
        logic         to;
        logic         crc;
    } exp_t;

    typedef struct {
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic         rexp;
        logic         rlong;
        logic         to_en;
        logic         early;
        int           nbits;
        int           dly;
        logic [135:0] card;
        logic [47:0]  ef;
        logic [127:0] er;
        logic         eto;
        logic         ecrc;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC7 by polynomial long division.
    function automatic logic [6:0] crc7_ref(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'd0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] fr(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b01, idx, arg};
        return {h, crc7_ref(h), 1'b1};
    endfunction

    function automatic vec_t mk(input logic [5:0] idx, input logic [31:0] arg,
                                input logic rexp, input logic rlong, input logic to_en,
                                input logic early, input int nbits, input int dly,
                                input logic [135:0] card, input logic [47:0] ef,
                                input logic [127:0] er, input logic eto, input logic ecrc);
        vec_t v;
        v.idx = idx; v.arg = arg; v.rexp = rexp; v.rlong = rlong; v.to_en = to_en;
        v.early = early; v.nbits = nbits; v.dly = dly; v.card = card;
        v.ef = ef; v.er = er; v.eto = eto; v.ecrc = ecrc;
        return v;
    endfunction

    task automatic drive_card(input logic [135:0] f, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.cmd_pin_in = f[i];
            @(negedge clock);
        end
        bus.cmd_pin_in = 1'b1;
    endtask

    task automatic finish_txn(input logic early, input logic [127:0] er, input string tag);
        int n = 0;
        while (!bus.strobe_out && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (!bus.strobe_out) begin
            chk({tag, " strobe wait"}, 128'(0), 128'(1));
            bus.ack_out = 1'b0;
        end else if (early) begin
            @(negedge clock);
            chk({tag, " one-cycle strobe"}, 128'(bus.strobe_out), 128'(0));
            chk({tag, " idle after ack"}, 128'(bus.busy), 128'(0));
            bus.ack_out = 1'b0;
        end else begin
            @(negedge clock);
            chk({tag, " strobe held"}, 128'(bus.strobe_out), 128'(1));
            bus.ack_out = 1'b1;
            @(negedge clock);
            chk({tag, " strobe drop"}, 128'(bus.strobe_out), 128'(0));
            chk({tag, " idle after ack"}, 128'(bus.busy), 128'(0));
            bus.ack_out = 1'b0;
        end
        chk({tag, " response hold"}, bus.response, er);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n, k;
        logic [47:0] got;
        logic oe_all;
        exp_t e;
        n = 0;
        while (bus.busy && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (bus.busy) chk({tag, " idle wait"}, 128'(0), 128'(1));
        bus.cmd_index         = v.idx;
        bus.cmd_argument      = v.arg;
        bus.response_expected = v.rexp;
        bus.response_long     = v.rlong;
        bus.timeout_enable    = v.to_en;
        bus.ack_out           = v.early;
        bus.send_strobe       = 1'b1;
        k = cyc;
        if (!v.rexp) e.cyc = k + 49;
        else if (v.nbits == 0) e.cyc = k + 49 + RT;
        else e.cyc = k + 48 + v.dly + v.nbits;
        e.resp = v.er; e.to = v.eto; e.crc = v.ecrc;
        sb.push_back(e);
        @(negedge clock);
        bus.send_strobe = 1'b0;
        chk({tag, " busy at k+1"}, 128'(bus.busy), 128'(1));
        got = '0;
        oe_all = 1'b1;
        for (int i = 0; i < 48; i++) begin
            got = {got[46:0], bus.cmd_out};
            oe_all = oe_all & bus.cmd_oe;
            if (i < 47) @(negedge clock);
        end
        chk({tag, " frame"}, 128'(got), 128'(v.ef));
        chk({tag, " oe during frame"}, 128'(oe_all), 128'(1));
        @(negedge clock);
        chk({tag, " oe after end"}, 128'(bus.cmd_oe), 128'(0));
        if (v.nbits > 0) begin
            repeat (v.dly - 1) @(negedge clock);
            drive_card(v.card, v.nbits);
        end
        finish_txn(v.early, v.er, tag);
    endtask

    // Scoreboard check on every strobe_out rising edge.
    initial begin : monitor
        logic strobe_prev;
        exp_t e;
        strobe_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                strobe_prev = 1'b0;
            end else begin
                if (bus.strobe_out && !strobe_prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected strobe", 128'(1), 128'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("strobe cycle", 128'(cyc), 128'(e.cyc));
                        chk("response", bus.response, e.resp);
                        chk("time_out", 128'(bus.time_out), 128'(e.to));
                        chk("crc_error", 128'(bus.crc_error), 128'(e.crc));
                    end
                end
                strobe_prev = bus.strobe_out;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [39:0]  r17;
        logic [135:0] c17;
        logic [47:0]  exp48;
        logic [18:0]  got19;
        logic         seen;
        exp_t         e;
        int           k;

        r17 = 40'h1100000900;
        c17 = {88'd0, r17, crc7_ref(r17), 1'b1};
        vecs[0] = mk(6'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, '0,
                     48'h400000000095, '0, 1'b0, 1'b0);
        vecs[1] = mk(6'd8, 32'h1AA, 1'b1, 1'b0, 1'b1, 1'b0, 48, 2, 136'h08000001AA13,
                     48'h48000001AA87, 128'h08000001AA, 1'b0, 1'b0);
        vecs[2] = mk(6'd8, 32'h1AA, 1'b1, 1'b0, 1'b1, 1'b1, 48, 2, 136'h08000001AA01,
                     48'h48000001AA87, 128'h08000001AA, 1'b0, 1'b1);
        vecs[3] = mk(6'd55, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, '0,
                     fr(6'd55, 32'h0), '0, 1'b0, 1'b0);
        vecs[4] = mk(6'd8, 32'h1AA, 1'b1, 1'b0, 1'b1, 1'b0, 48, 1, 136'h08000001AA12,
                     48'h48000001AA87, 128'h08000001AA, 1'b0, 1'b1);
        vecs[5] = mk(6'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, '0,
                     48'h400000000095, '0, 1'b1, 1'b0);
        vecs[6] = mk(6'd58, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, '0,
                     fr(6'd58, 32'h0), '0, 1'b0, 1'b0);
        vecs[7] = mk(6'd2, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 136, 5,
                     136'h3FFFFF9999EEEE8888DDDD7777CCCC6666, fr(6'd2, 32'h0),
                     128'hFFFF9999EEEE8888DDDD7777CCCC6666, 1'b0, 1'b0);
        vecs[8] = mk(6'd17, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 48, 10, c17,
                     fr(6'd17, 32'h0), 128'h1100000900, 1'b0, 1'b0);

        reset                 = 1'b1;
        bus.send_strobe       = 1'b0;
        bus.cmd_index         = 6'd0;
        bus.cmd_argument      = 32'h0;
        bus.response_expected = 1'b0;
        bus.response_long     = 1'b0;
        bus.timeout_enable    = 1'b0;
        bus.ack_out           = 1'b0;
        bus.cmd_pin_in        = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset cmd_out", 128'(bus.cmd_out), 128'(1));
        chk("reset cmd_oe", 128'(bus.cmd_oe), 128'(0));
        chk("reset response", bus.response, 128'(0));
        chk("reset strobe", 128'(bus.strobe_out), 128'(0));
        chk("reset time_out", 128'(bus.time_out), 128'(0));
        chk("reset crc_error", 128'(bus.crc_error), 128'(0));
        chk("reset busy", 128'(bus.busy), 128'(0));
        reset = 1'b0;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Timeout disabled: wait well past RT, then the card finally answers.
        bus.cmd_index         = 6'd8;
        bus.cmd_argument      = 32'h1AA;
        bus.response_expected = 1'b1;
        bus.response_long     = 1'b0;
        bus.timeout_enable    = 1'b0;
        bus.send_strobe       = 1'b1;
        @(negedge clock);
        bus.send_strobe = 1'b0;
        repeat (48) @(negedge clock);
        seen = 1'b0;
        for (int i = 0; i < 4 * RT; i++) begin
            if (bus.strobe_out) seen = 1'b1;
            @(negedge clock);
        end
        chk("no-timeout strobe", 128'(seen), 128'(0));
        chk("no-timeout busy", 128'(bus.busy), 128'(1));
        e.cyc = cyc + 48; e.resp = 128'h08000001AA; e.to = 1'b0; e.crc = 1'b0;
        sb.push_back(e);
        drive_card(136'h08000001AA13, 48);
        finish_txn(1'b0, 128'h08000001AA, "late resp");

        // Reset at the 20th SEND bit, with a stray send_strobe earlier in SEND.
        exp48 = 48'h48000001AA87;
        bus.timeout_enable = 1'b1;
        bus.send_strobe    = 1'b1;
        k = cyc;
        @(negedge clock);
        bus.send_strobe = 1'b0;
        got19 = '0;
        for (int i = 1; i < 20; i++) begin
            got19 = {got19[17:0], bus.cmd_out};
            if (i == 6) bus.send_strobe = 1'b1;
            if (i == 7) bus.send_strobe = 1'b0;
            @(negedge clock);
        end
        chk("abort frame prefix", 128'(got19), 128'(exp48[47:29]));
        chk("abort cycle", 128'(cyc), 128'(k + 20));
        reset = 1'b1;
        #1;
        chk("abort cmd_oe", 128'(bus.cmd_oe), 128'(0));
        chk("abort cmd_out", 128'(bus.cmd_out), 128'(1));
        chk("abort busy", 128'(bus.busy), 128'(0));
        chk("abort strobe", 128'(bus.strobe_out), 128'(0));
        @(negedge clock);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (bus.strobe_out || bus.busy) seen = 1'b1;
            @(negedge clock);
        end
        chk("abort quiet", 128'(seen), 128'(0));
        run_vec(vecs[1], "after abort");

        repeat (3) @(negedge clock);
        chk("scoreboard drained", 128'(sb.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
